dma_lite_cfg_writer: RTL and testbench
======================================

# dma_lite_cfg_writer

Configures one S2MM transfer on the AXI DMA over AXI4-Lite. It writes S2MM_DMACR, S2MM_DA and S2MM_LENGTH in that order, then starts the downstream DMASR status poller and waits for its dma_idle indication. It sits upstream of the status poller: its poll_start output drives the poller's start input, and the poller's dma_idle output returns as this block's dma_idle input.

## Interface
Parameters:
- ADDR_W, 10, AXI-Lite address width
- LEN_W, 26, significant bits of cfg_len
- TIMEOUT_CYC, 1_000_000, maximum cycles in WAIT_IDLE before a timeout error

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- cfg_addr  in  32  destination address; latched on accepted start
- cfg_len  in  LEN_W  byte count; latched on accepted start
- m_axi_lite_awaddr  out  ADDR_W  write address
- m_axi_lite_awvalid  out  1  write-address valid
- m_axi_lite_awready  in  1  write-address ready
- m_axi_lite_wdata  out  32  write data
- m_axi_lite_wstrb  out  4  write strobes
- m_axi_lite_wvalid  out  1  write-data valid
- m_axi_lite_wready  in  1  write-data ready
- m_axi_lite_bresp  in  2  write response
- m_axi_lite_bvalid  in  1  write-response valid
- m_axi_lite_bready  out  1  write-response ready
- poll_start  out  1  one-cycle pulse to the status poller
- dma_idle  in  1  completion pulse from the status poller
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error flag; cleared by the next accepted start
- err_code  out  2  error cause: 0 none, 1 SLVERR/DECERR, 2 zero length, 3 timeout

## Operation
- States: IDLE, SEND, RESP, KICK, WAIT_IDLE.
- IDLE:
  - start with cfg_len==0: set err=1 and err_code=2. No bus activity; remain in IDLE.
  - start with cfg_len!=0: latch cfg_addr and cfg_len, clear err and err_code, set idx=0, go to SEND.
- Register sequence by idx:
  - idx 0: address 0x30, data 0x0000_0001 (RS bit).
  - idx 1: address 0x48, data cfg_addr.
  - idx 2: address 0x58, data zero-extended cfg_len.
  - LENGTH is always written last because that write starts the DMA.
- SEND:
  - awvalid and wvalid rise together.
  - Each valid drops independently the cycle after its own handshake (valid&ready).
  - Move to RESP when both handshakes are done, including when both complete in the same cycle.
- RESP: bready=1. On bvalid:
  - bresp!=0: set err=1 and err_code=1, go to IDLE. No poll_start is issued.
  - bresp==0 and idx<2: increment idx, go to SEND.
  - bresp==0 and idx==2: go to KICK.
- KICK: poll_start=1 for exactly one cycle, then go to WAIT_IDLE and clear the timeout counter.
- WAIT_IDLE:
  - dma_idle: done=1 for one cycle, go to IDLE.
  - Counter reaches TIMEOUT_CYC: set err=1 and err_code=3, go to IDLE.
  - If dma_idle and the timeout occur in the same cycle, dma_idle wins.
- Outputs when not valid: awaddr=0, wdata=0, wstrb=0. wstrb=4'hF while wvalid is high.
- start while busy is ignored and is not queued.
- rst mid-transaction: immediate return to IDLE. Outstanding AXI handshakes are abandoned; the system resets the slave together with this block.

## Timing
- All outputs are registered.
- Reset value of every output is 0, including err and err_code.
- Latency with awready=wready=1 and bvalid on the first RESP cycle:
  - start accepted at cycle 0.
  - SEND at cycles 1, 3, 5; RESP at cycles 2, 4, 6.
  - poll_start at cycle 7; WAIT_IDLE from cycle 8.
  - done is asserted 1 cycle after the dma_idle pulse.
- busy is high from cycle 1 through the done cycle inclusive. It drops in the cycle after a done or error exit.
- A new start is accepted on the first cycle after busy falls.
- Minimum cost is 2 cycles per register write.
- Backpressure on awready, wready or bvalid extends SEND or RESP indefinitely. No timeout applies in those states.

## Structure
- Shared package `dma_lite_pkg`:
  - register offsets DMACR=0x30, DA=0x48, LENGTH=0x58, DMASR=0x34
  - RS-bit constant
  - err_code enumeration
  - state one-hot constants
- One natural sub-module, `axil_single_write`. It performs one AW/W/B transaction and reports done and resp. The top FSM sequences idx through it.

## Test plan
- Always-ready slave, cfg_addr=0x1000_0000, cfg_len=0x100:
  - writes in order (0x30, 1), (0x48, 0x1000_0000), (0x58, 0x100)
  - poll_start at cycle 7
  - dma_idle at cycle 12 -> done at cycle 13, err=0
- awready delayed 3 cycles, wready immediate:
  - wvalid drops after 1 cycle; awvalid is held for 4 cycles
  - exactly one B handshake per register
- bresp=2'b10 on the DA write:
  - err=1, err_code=1, no LENGTH write, no poll_start
  - busy falls the next cycle
- start with cfg_len=0 -> err_code=2, awvalid never asserts, busy stays 0.
- TIMEOUT_CYC=16 with dma_idle never pulsed -> err_code=3 exactly 16 cycles after WAIT_IDLE entry. A following good start clears err.
- rst asserted during RESP of the DMACR write -> all outputs 0 the next cycle. start accepted 1 cycle after rst deasserts.

Source files
------------

// File: rtl/dma_lite_pkg.sv
// dma_lite_pkg: AXI DMA S2MM register map, error codes and FSM state encodings
package dma_lite_pkg;
  localparam logic [11:0] REG_DMACR  = 12'h030;
  localparam logic [11:0] REG_DMASR  = 12'h034;
  localparam logic [11:0] REG_DA     = 12'h048;
  localparam logic [11:0] REG_LENGTH = 12'h058;
  localparam logic [31:0] DMACR_RS   = 32'h0000_0001;
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RESP     = 2'd1,
    ERR_ZERO_LEN = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_e;
  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_SEND = 5'b00010;
  localparam logic [4:0] S_RESP = 5'b00100;
  localparam logic [4:0] S_KICK = 5'b01000;
  localparam logic [4:0] S_WAIT = 5'b10000;
endpackage

// File: rtl/axil_single_write.sv
// axil_single_write: one AXI4-Lite AW/W/B write with registered channel outputs
module axil_single_write #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              sent,
  output logic              done,
  output logic [1:0]        resp
);
  assign sent = (awvalid || wvalid) && (!awvalid || awready) && (!wvalid || wready);
  assign done = bready && bvalid;
  assign resp = bresp;
  always_ff @(posedge clk) begin
    if (rst) begin
      awaddr  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
    end else begin
      if (req) begin
        awaddr  <= addr;
        awvalid <= 1'b1;
        wdata   <= data;
        wstrb   <= 4'hF;
        wvalid  <= 1'b1;
      end else begin
        if (awvalid && awready) begin
          awaddr  <= '0;
          awvalid <= 1'b0;
        end
        if (wvalid && wready) begin
          wdata  <= '0;
          wstrb  <= '0;
          wvalid <= 1'b0;
        end
      end
      if (sent) bready <= 1'b1;
      else if (done) bready <= 1'b0;
    end
  end
endmodule

// File: rtl/dma_lite_cfg_writer.sv
// dma_lite_cfg_writer: programs DMACR, DA, LENGTH over AXI-Lite, then kicks the status poller
module dma_lite_cfg_writer
  import dma_lite_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int LEN_W       = 26,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       cfg_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic [ADDR_W-1:0] m_axi_lite_awaddr,
  output logic              m_axi_lite_awvalid,
  input  logic              m_axi_lite_awready,
  output logic [31:0]       m_axi_lite_wdata,
  output logic [3:0]        m_axi_lite_wstrb,
  output logic              m_axi_lite_wvalid,
  input  logic              m_axi_lite_wready,
  input  logic [1:0]        m_axi_lite_bresp,
  input  logic              m_axi_lite_bvalid,
  output logic              m_axi_lite_bready,
  output logic              poll_start,
  input  logic              dma_idle,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [4:0]        state;
  logic [1:0]        idx;
  logic [31:0]       addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [CW-1:0]     cnt;
  logic              go, nxt, req, sent, wr_done;
  logic [1:0]        wr_resp;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  // the next write is chosen one cycle early so its valids are registered on SEND entry
  always_comb begin
    go       = state == S_IDLE && !busy && start && cfg_len != '0;
    nxt      = state == S_RESP && wr_done && wr_resp == 2'b00 && idx != 2'd2;
    req      = go || nxt;
    req_addr = go ? ADDR_W'(REG_DMACR) : idx == 2'd0 ? ADDR_W'(REG_DA) : ADDR_W'(REG_LENGTH);
    req_data = go ? DMACR_RS : idx == 2'd0 ? addr_q : 32'(len_q);
  end
  axil_single_write #(.ADDR_W(ADDR_W)) u_wr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .addr    (req_addr),
    .data    (req_data),
    .awaddr  (m_axi_lite_awaddr),
    .awvalid (m_axi_lite_awvalid),
    .awready (m_axi_lite_awready),
    .wdata   (m_axi_lite_wdata),
    .wstrb   (m_axi_lite_wstrb),
    .wvalid  (m_axi_lite_wvalid),
    .wready  (m_axi_lite_wready),
    .bresp   (m_axi_lite_bresp),
    .bvalid  (m_axi_lite_bvalid),
    .bready  (m_axi_lite_bready),
    .sent    (sent),
    .done    (wr_done),
    .resp    (wr_resp)
  );
  // busy lags the return to IDLE by one cycle so it covers the done/err exit cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      poll_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      poll_start <= 1'b0;
      done       <= 1'b0;
      busy       <= state != S_IDLE || go;
      case (state)
        S_IDLE:
          if (go) begin
            addr_q   <= cfg_addr;
            len_q    <= cfg_len;
            idx      <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            state    <= S_SEND;
          end else if (start && !busy) begin
            err      <= 1'b1;
            err_code <= ERR_ZERO_LEN;
          end
        S_SEND:
          if (sent) state <= S_RESP;
        S_RESP:
          if (wr_done) begin
            if (wr_resp != 2'b00) begin
              err      <= 1'b1;
              err_code <= ERR_RESP;
              state    <= S_IDLE;
            end else if (idx == 2'd2) begin
              poll_start <= 1'b1;
              state      <= S_KICK;
            end else begin
              idx   <= idx + 2'd1;
              state <= S_SEND;
            end
          end
        S_KICK: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT:
          if (dma_idle) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_lite_cfg_writer.sv
// tb_dma_lite_cfg_writer: directed tests with a simple AXI-Lite slave model
module tb_dma_lite_cfg_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [25:0] cfg_len = '0;
  logic [9:0]  awaddr;
  logic        awvalid, wvalid, bready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = 2'b00;
  logic        poll_start, busy, done, err;
  logic        dma_idle = 1'b0;
  logic [1:0]  err_code;
  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0;
  int aw_delay = 0, b_err_idx = -1, av_cnt = 0;
  int aw_n = 0, w_n = 0, b_n = 0, aw_hi = 0, w_hi = 0, poll_n = 0, poll_cyc = 0, strb_bad = 0;
  logic [9:0]  aw_log [8];
  int          aw_cyc [8];
  logic [31:0] w_log [8];

  dma_lite_cfg_writer #(.ADDR_W(10), .LEN_W(26), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb), .m_axi_lite_wvalid(wvalid),
    .m_axi_lite_wready(wready), .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid),
    .m_axi_lite_bready(bready), .poll_start(poll_start), .dma_idle(dma_idle),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    av_cnt = awvalid ? av_cnt + 1 : 0;
    awready = awvalid && av_cnt > aw_delay;
    wready = wvalid;
    bvalid = bready;
    bresp = (b_n == b_err_idx) ? 2'b10 : 2'b00;
    if (awvalid) aw_hi++;
    if (wvalid) begin
      w_hi++;
      if (wstrb !== 4'hF) strb_bad++;
    end
    if (awvalid && awready && aw_n < 8) begin
      aw_log[aw_n] = awaddr;
      aw_cyc[aw_n] = cyc;
      aw_n++;
    end
    if (wvalid && wready && w_n < 8) begin
      w_log[w_n] = wdata;
      w_n++;
    end
    if (bvalid && bready) b_n++;
    if (poll_start) begin
      poll_n++;
      poll_cyc = cyc;
    end
  end

  task automatic clear_logs;
    aw_n = 0; w_n = 0; b_n = 0; aw_hi = 0; w_hi = 0; poll_n = 0; poll_cyc = 0; strb_bad = 0;
  endtask

  task automatic go(input logic [31:0] a, input logic [25:0] l);
    @(negedge clk);
    cfg_addr = a;
    cfg_len = l;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic to_rel(input int k);
    while (cyc - t0 < k) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready, poll_start, busy, done, err} !== 7'b0 || err_code !== 2'd0 ||
        awaddr !== 10'd0 || wdata !== 32'd0 || wstrb !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs got ctl=%b code=%0d aw=%h wd=%h ws=%h exp all zero",
               {awvalid, wvalid, bready, poll_start, busy, done, err}, err_code, awaddr, wdata, wstrb);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    clear_logs();
    go(32'h1000_0000, 26'h100);
    checks++;
    if (busy !== 1'b1 || awvalid !== 1'b1 || awaddr !== 10'h030) begin
      errors++;
      $display("FAIL basic_cycle1 got busy=%b awvalid=%b awaddr=%h exp 1 1 030", busy, awvalid, awaddr);
    end
    to_rel(12);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_wait got done=%b busy=%b exp 0 1", done, busy);
    end
    dma_idle = 1'b1;
    @(negedge clk);
    dma_idle = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done got done=%b err=%b busy=%b exp 1 0 1", done, err, busy);
    end
    checks++;
    if (aw_n !== 3 || aw_log[0] !== 10'h030 || aw_log[1] !== 10'h048 || aw_log[2] !== 10'h058) begin
      errors++;
      $display("FAIL basic_addrs got n=%0d %h %h %h exp 3 030 048 058", aw_n, aw_log[0], aw_log[1], aw_log[2]);
    end
    checks++;
    if (w_n !== 3 || w_log[0] !== 32'h1 || w_log[1] !== 32'h1000_0000 || w_log[2] !== 32'h100 || strb_bad != 0) begin
      errors++;
      $display("FAIL basic_data got n=%0d %h %h %h strb_bad=%0d exp 3 1 10000000 100 0",
               w_n, w_log[0], w_log[1], w_log[2], strb_bad);
    end
    checks++;
    if (aw_cyc[0] - t0 != 1 || aw_cyc[1] - t0 != 3 || aw_cyc[2] - t0 != 5 || poll_cyc - t0 != 7 || poll_n != 1) begin
      errors++;
      $display("FAIL basic_timing got aw@%0d,%0d,%0d poll@%0d n=%0d exp 1,3,5 7 1",
               aw_cyc[0] - t0, aw_cyc[1] - t0, aw_cyc[2] - t0, poll_cyc - t0, poll_n);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_backpressure;
    clear_logs();
    aw_delay = 3;
    go(32'h2000_0040, 26'h3FF_FFFF);
    for (int i = 0; i < 100 && poll_start !== 1'b1; i++) @(negedge clk);
    checks++;
    if (poll_start !== 1'b1) begin
      errors++;
      $display("FAIL bp_poll got poll_start=%b exp 1 within 100 cycles", poll_start);
    end
    @(negedge clk);
    dma_idle = 1'b1;
    @(negedge clk);
    dma_idle = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done got %b exp 1", done);
    end
    checks++;
    if (aw_hi != 12 || w_hi != 3 || b_n != 3 || aw_n != 3 || w_log[2] !== 32'h03FF_FFFF) begin
      errors++;
      $display("FAIL bp_counts got aw_hi=%0d w_hi=%0d b=%0d aw=%0d len=%h exp 12 3 3 3 03ffffff",
               aw_hi, w_hi, b_n, aw_n, w_log[2]);
    end
    aw_delay = 0;
    @(negedge clk);
  endtask

  task automatic test_bresp_err;
    clear_logs();
    b_err_idx = 1;
    go(32'h3000_0000, 26'h40);
    for (int i = 0; i < 50 && err !== 1'b1; i++) @(negedge clk);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1) begin
      errors++;
      $display("FAIL berr_code got err=%b code=%0d exp 1 1", err, err_code);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL berr_busy got %b exp 0", busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (aw_n != 2 || b_n != 2 || poll_n != 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL berr_stop got aw=%0d b=%0d poll=%0d err=%b exp 2 2 0 1", aw_n, b_n, poll_n, err);
    end
    b_err_idx = -1;
  endtask

  task automatic test_zero_len;
    clear_logs();
    go(32'h4000_0000, 26'h0);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zlen_code got err=%b code=%0d busy=%b exp 1 2 0", err, err_code, busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (aw_hi != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zlen_quiet got aw_hi=%0d busy=%b exp 0 0", aw_hi, busy);
    end
  endtask

  task automatic test_timeout;
    clear_logs();
    go(32'h5000_0000, 26'h80);
    to_rel(23);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early got err=%b busy=%b exp 0 1", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd3) begin
      errors++;
      $display("FAIL tmo_code got err=%b code=%0d exp 1 3", err, err_code);
    end
    @(negedge clk);
    go(32'h5000_1000, 26'h80);
    checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL tmo_clear got err=%b code=%0d exp 0 0", err, err_code);
    end
    to_rel(23);
    dma_idle = 1'b1;
    @(negedge clk);
    dma_idle = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle_wins got done=%b err=%b exp 1 0", done, err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    clear_logs();
    go(32'h6000_0000, 26'h20);
    to_rel(2);
    checks++;
    if (bready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_resp got bready=%b exp 1", bready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({awvalid, wvalid, bready, poll_start, busy, done, err} !== 7'b0 || err_code !== 2'd0 ||
        awaddr !== 10'd0 || wdata !== 32'd0 || wstrb !== 4'd0) begin
      errors++;
      $display("FAIL rmid_zero got ctl=%b code=%0d aw=%h wd=%h ws=%h exp all zero",
               {awvalid, wvalid, bready, poll_start, busy, done, err}, err_code, awaddr, wdata, wstrb);
    end
    go(32'h6000_0100, 26'h20);
    checks++;
    if (busy !== 1'b1 || awvalid !== 1'b1 || awaddr !== 10'h030) begin
      errors++;
      $display("FAIL rmid_restart got busy=%b awvalid=%b awaddr=%h exp 1 1 030", busy, awvalid, awaddr);
    end
    to_rel(10);
    dma_idle = 1'b1;
    @(negedge clk);
    dma_idle = 1'b0;
    checks++;
    if (done !== 1'b1 || w_log[w_n - 2] !== 32'h6000_0100) begin
      errors++;
      $display("FAIL rmid_done got done=%b da=%h exp 1 60000100", done, w_log[w_n - 2]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bresp_err();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
